// File: rtl/ysyx_22041071_mem_pkg.sv
// Shared types and helpers for the core's single-port RAMHelper path:
// arbiter state, requester encoding, memory base and index mapping.
package ysyx_22041071_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  localparam logic [63:0] START_ADDR = 64'h8000_0000;
  localparam logic [2:0]  STARVE_MAX = 3'd4;

  // RAMHelper addresses 64-bit words relative to the physical base.
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr);
    return (addr - START_ADDR) >> 3;
  endfunction

endpackage

// File: rtl/ysyx_22041071_arb_pick.sv
// Grant selection between IF and LS: LS wins unless IF has been passed over
// STARVE_MAX times in a row while it was waiting.
module ysyx_22041071_arb_pick
  import ysyx_22041071_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic if_req_valid,
  input  logic ls_req_valid,
  input  logic if_flush,
  output logic if_req_ready,
  output logic ls_req_ready
);

  logic [2:0] starve_cnt_q, starve_cnt_d;
  logic       force_if;

  always_comb begin
    force_if     = (starve_cnt_q == STARVE_MAX) & if_req_valid;
    ls_req_ready = idle & ~reset & ls_req_valid & ~force_if;
    if_req_ready = idle & ~reset & ~if_flush & (~ls_req_valid | force_if);

    starve_cnt_d = starve_cnt_q;
    if (if_req_valid & if_req_ready) begin
      starve_cnt_d = 3'd0;
    end else if (ls_req_valid & ls_req_ready & if_req_valid &
                 (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= 3'd0;
    else       starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/ysyx_22041071_mem_arb.sv
// Shares the single RAMHelper port between instruction fetch and load/store:
// one transaction at a time through IDLE -> ISSUE -> RESP.
module ysyx_22041071_mem_arb
  import ysyx_22041071_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [31:0] if_rsp_ins,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_req_addr,
  input  logic        ls_req_wen,
  input  logic [63:0] ls_req_wdata,
  input  logic [63:0] ls_req_wmask,
  output logic        ls_rsp_valid,
  input  logic        ls_rsp_ready,
  output logic [63:0] ls_rsp_rdata,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [63:0] mem_ridx,
  output logic [63:0] mem_widx,
  output logic [63:0] mem_wdata,
  output logic [63:0] mem_wmask,
  input  logic [63:0] mem_rdata
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic        killed_q, killed_d;
  logic        first_q, first_d;
  logic        hi_q, hi_d;
  logic        wen_q, wen_d;
  logic [63:0] idx_q, idx_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] wmask_q, wmask_d;
  logic [31:0] if_ins_q, if_ins_d;
  logic [63:0] ls_rdata_q, ls_rdata_d;
  logic [31:0] live_ins;
  logic [63:0] live_rdata;

  ysyx_22041071_arb_pick u_pick (
    .clk          (clk),
    .reset        (reset),
    .idle         (state_q == ST_IDLE),
    .if_req_valid (if_req_valid),
    .ls_req_valid (ls_req_valid),
    .if_flush     (if_flush),
    .if_req_ready (if_req_ready),
    .ls_req_ready (ls_req_ready)
  );

  assign mem_ridx  = idx_q;
  assign mem_widx  = idx_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  // Read data arrives only in the first RESP cycle; it is forwarded live
  // then and served from the capture register afterwards.
  assign live_ins   = hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
  assign live_rdata = wen_q ? 64'd0 : mem_rdata;

  always_comb begin
    // NOTE: every _d and output takes a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    owner_d      = owner_q;
    killed_d     = killed_q;
    first_d      = 1'b0;
    hi_d         = hi_q;
    wen_d        = wen_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    if_ins_d     = if_ins_q;
    ls_rdata_d   = ls_rdata_q;
    mem_en       = 1'b0;
    mem_wen      = 1'b0;
    if_rsp_valid = 1'b0;
    ls_rsp_valid = 1'b0;
    if_rsp_ins   = if_ins_q;
    ls_rsp_rdata = ls_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (ls_req_valid & ls_req_ready) begin
          state_d  = ST_ISSUE;
          owner_d  = OWN_LS;
          killed_d = 1'b0;
          idx_d    = addr_to_idx(ls_req_addr);
          hi_d     = ls_req_addr[2];
          wen_d    = ls_req_wen;
          wdata_d  = ls_req_wdata;
          wmask_d  = ls_req_wmask;
        end else if (if_req_valid & if_req_ready) begin
          state_d  = ST_ISSUE;
          owner_d  = OWN_IF;
          killed_d = 1'b0;
          idx_d    = addr_to_idx(if_req_addr);
          hi_d     = if_req_addr[2];
          wen_d    = 1'b0;
          wdata_d  = 64'd0;
          wmask_d  = 64'd0;
        end
      end
      ST_ISSUE: begin
        // Reset in this cycle must keep the RAM from committing a write.
        mem_en  = ~reset;
        mem_wen = wen_q & ~reset;
        if ((owner_q == OWN_IF) & if_flush) killed_d = 1'b1;
        state_d = ST_RESP;
        first_d = 1'b1;
      end
      ST_RESP: begin
        if (owner_q == OWN_IF) begin
          if (killed_q) begin
            state_d = ST_IDLE;
          end else begin
            if_rsp_valid = ~reset;
            if (first_q) begin
              if_rsp_ins = live_ins;
              if_ins_d   = live_ins;
            end
            if (if_flush)     killed_d = 1'b1;
            if (if_rsp_ready) state_d  = ST_IDLE;
          end
        end else begin
          ls_rsp_valid = ~reset;
          if (first_q) begin
            ls_rsp_rdata = live_rdata;
            ls_rdata_d   = live_rdata;
          end
          if (ls_rsp_ready) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset as well because their values
  // drive the memory index/data ports and response data directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      killed_q   <= 1'b0;
      first_q    <= 1'b0;
      hi_q       <= 1'b0;
      wen_q      <= 1'b0;
      idx_q      <= 64'd0;
      wdata_q    <= 64'd0;
      wmask_q    <= 64'd0;
      if_ins_q   <= 32'd0;
      ls_rdata_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      killed_q   <= killed_d;
      first_q    <= first_d;
      hi_q       <= hi_d;
      wen_q      <= wen_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      if_ins_q   <= if_ins_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_mem_arb.sv
// Bench for the IF/LS memory arbiter: directed vector table, hand-written
// flush/reset sequences and a randomized run against a transaction model.
module tb_ysyx_22041071_mem_arb;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_flush;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid, if_rsp_ready;
  logic [31:0] if_rsp_ins;
  logic        ls_req_valid, ls_req_ready, ls_req_wen;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_req_wmask;
  logic        ls_rsp_valid, ls_rsp_ready;
  logic [63:0] ls_rsp_rdata;
  logic        mem_en, mem_wen;
  logic [63:0] mem_ridx, mem_widx, mem_wdata, mem_wmask;
  logic [63:0] mem_rdata = 64'd0;

  always #5 clk = ~clk;

  ysyx_22041071_mem_arb dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_flush     (if_flush),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_ins   (if_rsp_ins),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wen   (ls_req_wen),
    .ls_req_wdata (ls_req_wdata),
    .ls_req_wmask (ls_req_wmask),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_ready (ls_rsp_ready),
    .ls_rsp_rdata (ls_rsp_rdata),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_ridx     (mem_ridx),
    .mem_widx     (mem_widx),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rdata    (mem_rdata)
  );

  function automatic logic [63:0] seed_word(input int i);
    if (i == 0) return 64'h1111_2222_3333_4444;
    return {32'(i) * 32'h9E37_79B9, ~(32'(i) * 32'h85EB_CA6B)};
  endfunction

  // RAMHelper stand-in: registered read, masked write, read-before-write.
  logic [63:0] env_mem [0:255];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= seed_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= env_mem[mem_ridx[7:0]];
      if (mem_wen)
        env_mem[mem_widx[7:0]] <= (env_mem[mem_widx[7:0]] & ~mem_wmask) |
                                  (mem_wdata & mem_wmask);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ifv;
    logic        flush;
    logic [63:0] if_addr;
    logic        lsv;
    logic [63:0] ls_addr;
    logic        wen;
    logic [63:0] wdata;
    logic [63:0] wmask;
    int          exp_grant;  // 0 none, 1 IF, 2 LS
    logic [63:0] exp_data;
    int          delay;      // cycles rsp_ready is held low
  } vec_t;

  function automatic vec_t mk(input logic ifv, input logic flush, input logic [63:0] if_addr,
                              input logic lsv, input logic [63:0] ls_addr, input logic wen,
                              input logic [63:0] wdata, input logic [63:0] wmask,
                              input int exp_grant, input logic [63:0] exp_data, input int delay);
    vec_t v;
    v.ifv = ifv; v.flush = flush; v.if_addr = if_addr;
    v.lsv = lsv; v.ls_addr = ls_addr; v.wen = wen; v.wdata = wdata; v.wmask = wmask;
    v.exp_grant = exp_grant; v.exp_data = exp_data; v.delay = delay;
    return v;
  endfunction

  task automatic clear_inputs();
    if_req_valid = 0; if_flush = 0; if_req_addr = BASE; if_rsp_ready = 0;
    ls_req_valid = 0; ls_req_addr = BASE; ls_req_wen = 0;
    ls_req_wdata = 0; ls_req_wmask = 0; ls_rsp_ready = 0;
  endtask

  // One full transaction: offer at IDLE, check ISSUE, then the response
  // with optional backpressure while both requesters keep pushing.
  task automatic do_txn(input vec_t v, input string tag);
    int          got;
    logic [63:0] a, eidx;
    @(negedge clk);
    clear_inputs();
    if_req_valid = v.ifv; if_flush = v.flush; if_req_addr = v.if_addr;
    ls_req_valid = v.lsv; ls_req_addr = v.ls_addr; ls_req_wen = v.wen;
    ls_req_wdata = v.wdata; ls_req_wmask = v.wmask;
    #1;
    check({tag, " idle rsp_valid"}, {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    check({tag, " ready exclusive"}, {63'd0, if_req_ready & ls_req_ready}, 64'd0);
    got = (ls_req_valid & ls_req_ready) ? 2 : (if_req_valid & if_req_ready) ? 1 : 0;
    check({tag, " grant"}, 64'(got), 64'(v.exp_grant));
    @(posedge clk);
    if (v.exp_grant == 0) return;

    a    = (v.exp_grant == 2) ? v.ls_addr : v.if_addr;
    eidx = (a - BASE) / 64'd8;
    @(negedge clk);
    if_flush = 0; if_req_valid = 1; ls_req_valid = 1;
    #1;
    check({tag, " issue mem_en"}, {63'd0, mem_en}, 64'd1);
    check({tag, " issue mem_wen"}, {63'd0, mem_wen}, {63'd0, (v.exp_grant == 2) && v.wen});
    check({tag, " issue ridx"}, mem_ridx, eidx);
    check({tag, " issue widx"}, mem_widx, eidx);
    if (v.exp_grant == 2 && v.wen) begin
      check({tag, " issue wdata"}, mem_wdata, v.wdata);
      check({tag, " issue wmask"}, mem_wmask, v.wmask);
    end
    check({tag, " issue readies"}, {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    @(posedge clk);

    for (int d = 0; d <= v.delay; d++) begin
      @(negedge clk);
      if (v.exp_grant == 1) if_rsp_ready = (d == v.delay);
      else                  ls_rsp_ready = (d == v.delay);
      #1;
      check({tag, " resp mem_en"}, {63'd0, mem_en}, 64'd0);
      check({tag, " resp readies"}, {62'd0, if_req_ready, ls_req_ready}, 64'd0);
      if (v.exp_grant == 1) begin
        check({tag, " if_rsp_valid"}, {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd2);
        check({tag, " if_rsp_ins"}, {32'd0, if_rsp_ins}, {32'd0, v.exp_data[31:0]});
      end else begin
        check({tag, " ls_rsp_valid"}, {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd1);
        check({tag, " ls_rsp_rdata"}, ls_rsp_rdata, v.exp_data);
      end
      @(posedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " readies"}, {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    check({tag, " rsp_valids"}, {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    check({tag, " mem enables"}, {62'd0, mem_en, mem_wen}, 64'd0);
    check({tag, " mem_ridx"}, mem_ridx, 64'd0);
    check({tag, " mem_widx"}, mem_widx, 64'd0);
    check({tag, " mem_wdata"}, mem_wdata, 64'd0);
    check({tag, " mem_wmask"}, mem_wmask, 64'd0);
    check({tag, " if_rsp_ins"}, {32'd0, if_rsp_ins}, 64'd0);
    check({tag, " ls_rsp_rdata"}, ls_rsp_rdata, 64'd0);
  endtask

  logic [63:0] ref_mem [0:255];
  vec_t        vecs [12];
  vec_t        v;
  int          starve;
  int          idx;
  logic [63:0] word;
  localparam logic [63:0] A10  = 64'h8000_0010;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DB   = 64'h0000_0000_DEAD_BEEF;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if_req_valid = 1; ls_req_valid = 1;
    #1;
    check_reset_values("por");
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    reset = 0;

    // Directed table: fetch, write/read-back, LS x4 then forced IF, flush in IDLE, backpressure.
    vecs[0]  = mk(1, 0, 64'h8000_0004, 0, A10, 0, 0, 0, 1, 64'h1111_2222, 0);
    vecs[1]  = mk(0, 0, BASE, 1, A10, 1, DB, ALL1, 2, 64'd0, 1);
    vecs[2]  = mk(0, 0, BASE, 1, A10, 0, 0, 0, 2, DB, 0);
    vecs[3]  = mk(1, 0, BASE, 1, A10, 0, 0, 0, 2, DB, 0);
    vecs[4]  = mk(1, 0, BASE, 1, A10, 0, 0, 0, 2, DB, 0);
    vecs[5]  = mk(1, 0, BASE, 1, A10, 0, 0, 0, 2, DB, 0);
    vecs[6]  = mk(1, 0, BASE, 1, A10, 0, 0, 0, 2, DB, 0);
    vecs[7]  = mk(1, 0, BASE, 1, A10, 0, 0, 0, 1, 64'h3333_4444, 0);
    vecs[8]  = mk(1, 0, BASE, 1, A10, 0, 0, 0, 2, DB, 0);
    vecs[9]  = mk(1, 1, BASE, 0, A10, 0, 0, 0, 0, 64'd0, 0);
    vecs[10] = mk(1, 1, BASE, 1, A10, 0, 0, 0, 2, DB, 0);
    vecs[11] = mk(1, 0, 64'h8000_0004, 0, A10, 0, 0, 0, 1, 64'h1111_2222, 5);
    for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // IF read killed by a flush in its ISSUE cycle; LS must follow at N+3.
    @(negedge clk);
    clear_inputs();
    if_req_valid = 1; if_req_addr = 64'h8000_0008;
    #1;
    check("flush accept", {63'd0, if_req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    if_req_valid = 0; if_flush = 1; if_rsp_ready = 1;
    #1;
    check("flush issue mem_en", {63'd0, mem_en}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    if_flush = 0;
    #1;
    check("flush no if_rsp_valid", {63'd0, if_rsp_valid}, 64'd0);
    @(posedge clk);
    do_txn(mk(0, 0, BASE, 1, A10, 0, 0, 0, 2, DB, 0), "after flush");

    // Reset lands in the ISSUE cycle of an LS write.
    @(negedge clk);
    clear_inputs();
    ls_req_valid = 1; ls_req_wen = 1; ls_req_addr = 64'h8000_0018;
    ls_req_wdata = 64'hCAFE_F00D_0BAD_BEEF; ls_req_wmask = ALL1;
    #1;
    check("rst write accept", {63'd0, ls_req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    ls_req_valid = 0; reset = 1;
    #1;
    check("rst issue mem_en", {63'd0, mem_en}, 64'd0);
    check("rst issue mem_wen", {63'd0, mem_wen}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    if_req_valid = 1; ls_req_valid = 1;
    #1;
    check_reset_values("rst issue");
    check("rst memory untouched", env_mem[3], seed_word(3));
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    reset = 0;

    // Randomized traffic in words 64..127 against a transaction-level model.
    starve = 0;
    for (int t = 0; t < 80; t++) begin
      v.ifv     = ($urandom_range(0, 3) != 0);
      v.lsv     = ($urandom_range(0, 3) != 0);
      v.flush   = 0;
      v.if_addr = BASE + 64'($urandom_range(64, 127) * 8 + $urandom_range(0, 1) * 4);
      v.ls_addr = BASE + 64'($urandom_range(64, 127) * 8);
      v.wen     = ($urandom_range(0, 1) == 1);
      v.wdata   = {$urandom, $urandom};
      v.wmask   = {$urandom, $urandom};
      v.delay   = $urandom_range(0, 3);
      v.exp_data = 64'd0;
      if (v.lsv && !(starve == 4 && v.ifv)) begin
        v.exp_grant = 2;
        idx = int'((v.ls_addr - BASE) / 64'd8);
        if (v.wen) ref_mem[idx] = (ref_mem[idx] & ~v.wmask) | (v.wdata & v.wmask);
        else       v.exp_data = ref_mem[idx];
        if (v.ifv && starve < 4) starve++;
      end else if (v.ifv) begin
        v.exp_grant = 1;
        idx  = int'((v.if_addr - BASE) / 64'd8);
        word = ref_mem[idx];
        v.exp_data = v.if_addr[2] ? {32'd0, word[63:32]} : {32'd0, word[31:0]};
        starve = 0;
      end else begin
        v.exp_grant = 0;
      end
      do_txn(v, $sformatf("rnd%0d", t));
    end

    @(negedge clk);
    clear_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
